// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and types for the seven-segment scan driver
//
// Contents:
//   SEG_OFF  - all segments and the decimal point dark (active-low)
//   SEG_DARK7 - the seven digit segments dark, decimal point excluded
//   AN_OFF   - all anodes disabled (active-low)
//   SEG_HEX  - active-low g..a patterns for hex digits 0..F, indexed by value
//   scan_state_e - scan FSM states
package seg_pkg;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [6:0] SEG_DARK7 = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Entry i holds the g..a pattern for hex value i; the leftmost entry is F.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - hex digit to active-low seven-segment pattern
//
// Ports:
//   value  in  [3:0] hex digit 0..F
//   seg_n  out [6:0] active-low segments g..a
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_HEX[value];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 4-digit common-anode display scanner
//
// Ports:
//   clock        in        system clock
//   reset_n      in        asynchronous active-low reset
//   value0..3    in  [3:0] digit values, value0 leftmost (an[3]) .. value3 rightmost (an[0])
//   dp_in        in  [3:0] decimal point enable, bit i belongs to an[i]
//   blank_in     in  [3:0] force digit fully dark, bit i belongs to an[i]
//   lzs          in        leading-zero suppression enable
//   seg          out [7:0] active-low segments, seg[7] = dp, seg[6:0] = g..a
//   an           out [3:0] active-low anode enables
//   frame_start  out       one-cycle pulse marking the input snapshot
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] value0,
    input  logic [3:0] value1,
    input  logic [3:0] value2,
    input  logic [3:0] value3,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank_in,
    input  logic       lzs,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int MAX_TICKS_RAW = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int MAX_TICKS     = (MAX_TICKS_RAW > 2) ? MAX_TICKS_RAW : 2;
    localparam int CNT_W         = $clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    scan_state_e      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shadow copy of the inputs; element k of shadow_val holds valuek.
    logic [3:0][3:0]  shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [3:0]       shadow_blank_q, shadow_blank_d;
    logic             shadow_lzs_q, shadow_lzs_d;

    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_start_q, frame_start_d;

    logic             blank_done;
    logic             on_done;
    logic             snap_en;
    logic [1:0]       an_pos;
    logic [3:0]       sel_val;
    logic [6:0]       dec_seg_n;
    logic             suppress;

    // Scan sequencing: counter reloads on every state change, so it never wraps.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + 1'b1;
        blank_done = (BLANK_TICKS == 0) || (cnt_q == BLANK_LAST);
        on_done    = (cnt_q == DIGIT_LAST);

        case (state_q)
            ST_BLANK: begin
                if (blank_done) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (on_done) begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                    state_d = (BLANK_TICKS == 0) ? ST_ON : ST_BLANK;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Snapshot on the first cycle of the value0 phase. Without a blank phase the
    // post-reset BLANK cycle is immediately followed by ON/idx0/cnt0; the still-high
    // frame_start_q stops that cycle from taking a second snapshot.
    always_comb begin
        snap_en = (idx_q == 2'd0) && (cnt_q == '0) &&
                  ((state_q == ST_BLANK) || ((BLANK_TICKS == 0) && !frame_start_q));

        shadow_val_d   = shadow_val_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        shadow_lzs_d   = shadow_lzs_q;
        if (snap_en) begin
            shadow_val_d   = {value3, value2, value1, value0};
            shadow_dp_d    = dp_in;
            shadow_blank_d = blank_in;
            shadow_lzs_d   = lzs;
        end
    end

    // Output decode works from the next shadow values so a digit lit on the
    // same cycle as the snapshot already shows the new frame's data.
    always_comb begin
        an_pos  = 2'd3 - idx_q;
        sel_val = shadow_val_d[idx_q];
    end

    seg_hex_decoder u_dec (
        .value (sel_val),
        .seg_n (dec_seg_n)
    );

    always_comb begin
        case (idx_q)
            2'd0:    suppress = (shadow_val_d[0] == 4'd0);
            2'd1:    suppress = (shadow_val_d[0] == 4'd0) && (shadow_val_d[1] == 4'd0);
            2'd2:    suppress = (shadow_val_d[0] == 4'd0) && (shadow_val_d[1] == 4'd0) &&
                                (shadow_val_d[2] == 4'd0);
            default: suppress = 1'b0;
        endcase
        suppress = suppress && shadow_lzs_d;

        an_d          = AN_OFF;
        seg_d         = SEG_OFF;
        frame_start_d = snap_en;
        if (state_q == ST_ON) begin
            an_d = ~(4'b0001 << an_pos);
            if (!shadow_blank_d[an_pos]) begin
                seg_d = {~shadow_dp_d[an_pos], suppress ? SEG_DARK7 : dec_seg_n};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_BLANK;
            idx_q          <= 2'd0;
            cnt_q          <= '0;
            shadow_val_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            shadow_lzs_q   <= 1'b0;
            seg_q          <= SEG_OFF;
            an_q           <= AN_OFF;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_lzs_q   <= shadow_lzs_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam int DT    = 4;
    localparam int BT    = 2;
    localparam int SLOT  = BT + DT;
    localparam int FRAME = 4 * SLOT;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] value0, value1, value2, value3;
    logic [3:0] dp_in, blank_in;
    logic       lzs;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame_start;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    logic [3:0] s_val [4];
    logic [3:0] s_dp, s_bl;
    logic       s_lzs;

    always #5 clock = ~clock;

    seg_scan_driver #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .value0      (value0),
        .value1      (value1),
        .value2      (value2),
        .value3      (value3),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lzs         (lzs),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_code(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Digit k (value k) sits on anode 3-k.
    function automatic logic [7:0] model_seg(input int k);
        logic       all_zero;
        logic [7:0] code;
        all_zero = 1'b1;
        for (int j = 0; j <= k; j++) begin
            if (s_val[j] != 4'd0) all_zero = 1'b0;
        end
        if (s_bl[3-k]) return 8'hFF;
        code = (s_lzs && k < 3 && all_zero) ? 8'hFF : hex_code(s_val[k]);
        if (s_dp[3-k]) code[7] = 1'b0;
        return code;
    endfunction

    task automatic set_inputs(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                              input logic [3:0] v3, input logic [3:0] dp, input logic [3:0] bl,
                              input logic lz);
        value0 = v0; value1 = v1; value2 = v2; value3 = v3;
        dp_in = dp; blank_in = bl; lzs = lz;
    endtask

    task automatic randomize_inputs();
        value0   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        value1   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        value2   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        value3   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        dp_in    = 4'($urandom);
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        lzs      = 1'($urandom);
    endtask

    // One clock: t counts edges since reset release; the edge with (t-1)%FRAME==0
    // takes the snapshot, and outputs after edge t show frame position (t-1)%FRAME.
    task automatic step(input bit rnd);
        int         p;
        int         k;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        @(posedge clock);
        t++;
        p = (t - 1) % FRAME;
        if (p == 0) begin
            s_val[0] = value0; s_val[1] = value1; s_val[2] = value2; s_val[3] = value3;
            s_dp = dp_in; s_bl = blank_in; s_lzs = lzs;
        end
        #1;
        if ((p % SLOT) < BT) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            k       = p / SLOT;
            exp_an  = ~(4'b1000 >> k);
            exp_seg = model_seg(k);
        end
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("frame_start", 32'(frame_start), 32'(p == 0));
        if (rnd && $urandom_range(0, 7) == 0) randomize_inputs();
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) step(rnd);
    endtask

    initial begin
        reset_n = 1'b0;
        set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b0000, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        check("reset_an", 32'(an), 32'h0000_000F);
        check("reset_seg", 32'(seg), 32'h0000_00FF);
        check("reset_fs", 32'(frame_start), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        t = 0;

        run(2 * FRAME, 1'b0);

        set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'b0000, 1'b1);
        run(FRAME, 1'b0);
        set_inputs(4'd0, 4'd5, 4'd0, 4'd7, 4'b0000, 4'b0000, 1'b1);
        run(FRAME, 1'b0);
        set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100, 4'b0001, 1'b0);
        run(FRAME, 1'b0);

        // Change value3 while digit 1 is lit; it must only appear next frame.
        set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b0000, 1'b0);
        run(SLOT + BT + 1, 1'b0);
        value3 = 4'd9;
        run(FRAME - (SLOT + BT + 1), 1'b0);
        run(FRAME, 1'b0);

        run(20 * FRAME, 1'b1);

        // Align to frame start, then land inside digit 1's ON window.
        while (((t - 1) % FRAME) != FRAME - 1) step(1'b0);
        run(SLOT + BT + 1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'h0000_000F);
        check("async_rst_seg", 32'(seg), 32'h0000_00FF);
        check("async_rst_fs", 32'(frame_start), 32'd0);
        set_inputs(4'd8, 4'd6, 4'd0, 4'd3, 4'b1000, 4'b0000, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        t = 0;
        run(3 * FRAME, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
